fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end for the five-stage MIPS pipeline. It replaces the bare PC counter plus IF/ID register with a PC generator, a fixed-latency instruction-memory request port and a DEPTH-entry prefetch queue. The decode stage drains the queue with a valid/ready handshake, and the execute stage redirects fetch on jumps and taken branches. Redirects flush the queue and squash any in-flight response.

## Interface
- ADDR_W, 32: PC and memory address width.
- DATA_W, 32: instruction width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC after reset.
- PC_STEP, 4: sequential PC increment.

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  request address (current fetch PC)
- imem_rdata  in  DATA_W  read data, valid exactly 1 cycle after imem_req
- redirect_valid  in  1  jump or taken branch from EX
- redirect_pc  in  ADDR_W  new fetch target
- instr_valid  out  1  queue head valid
- instr  out  DATA_W  head instruction
- instr_pc  out  ADDR_W  PC of head instruction
- instr_ready  in  1  decode accepts head (deasserted by the hazard bubbler)
- occupancy  out  log2(DEPTH)+1  entries held (debug and LED display)

## Operation
- State:
  - fetch_pc
  - inflight flag plus its pc and epoch
  - epoch bit
  - queue of {instr, pc}
  - count
- pop = instr_valid & instr_ready & ~redirect_valid.
- Request rule: imem_req = ~redirect_valid & (count + inflight − pop < DEPTH). Because pop is included, there is no bubble at steady state when DEPTH ≥ 2.
- On request: inflight←1, record fetch_pc and epoch, then fetch_pc ← fetch_pc + PC_STEP, wrapping modulo 2^ADDR_W.
- Response (cycle after a request): push {imem_rdata, recorded pc} only if the recorded epoch equals the current epoch and redirect_valid=0; otherwise drop it.
- Redirect, which has priority over all other events in the same cycle:
  - queue cleared, count←0
  - epoch toggled
  - fetch_pc ← redirect_pc
  - any response arriving this cycle or the next is discarded
  - pop is suppressed
  - no request is issued this cycle
- Simultaneous push and pop: count unchanged; head advances and tail advances.
- Full (count=DEPTH): no push can occur, because credits guarantee it. A push into a full queue is a design error and is flagged by an assertion.
- Empty: instr_valid=0; instr and instr_pc hold their last values.

## Timing
- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, instr=0, instr_pc=0
  - occupancy=0, epoch=0, inflight=0
- First request on the first rising edge after reset deasserts. imem_addr is combinational from fetch_pc.
- Fetch latency: request at cycle t, data at t+1, instr_valid from t+2. The queue head is registered show-ahead.
- Redirect latency: redirect at cycle t, imem_addr=redirect_pc with imem_req=1 at t+1, target instr_valid at t+3.
- Back-to-back redirects: the last one wins. Each toggles the epoch.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Any pending memory response is ignored because inflight=0.

## Structure
- The shared package `fetch_pkg` holds:
  - the queue-entry struct {instr, pc}
  - the RESET_PC and PC_STEP defaults
  - a clog2-based width helper for occupancy
- One sub-module, `fetch_fifo`: parametrised synchronous show-ahead FIFO with push, pop, flush, count and data in/out ports. Its flush takes priority over push and pop.
- The PC, epoch and credit logic live in `fetch_queue`.

## Test plan
- Reset release, instr_ready=1, memory returns addr ^ 32'hA5A5_0000:
  - addresses 0, 4, 8 … issued one per cycle
  - instr_valid from cycle 2
  - instr_pc increments by 4 every cycle, no gaps
- instr_ready=0 held for 10 cycles, DEPTH=4:
  - exactly 4 requests issued, then imem_req=0
  - occupancy=4, instr_pc stays 0
  - on release, 0, 4, 8, C drain in order, and the next request is issued in the same cycle as the first pop
- redirect_valid pulse with redirect_pc=0x100 while a request for 0x10 is in flight:
  - 0x10 data dropped, occupancy=0
  - next imem_addr=0x100
  - first valid instr_pc=0x100, three cycles after the redirect
- Redirect in the same cycle as pop and push with instr_ready=1: the queue is flushed, nothing is popped, and the next instr_pc equals redirect_pc.
- Wrap-around with ADDR_W=8, RESET_PC=0xF8:
  - PCs F8, FC, 00, 04 observed
  - occupancy never exceeds DEPTH
- Reset asserted mid-stream with 3 entries queued:
  - outputs return to reset values asynchronously
  - after release, fetch restarts at RESET_PC with no stale entries

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and defaults for the instruction-fetch front end.
//               Holds the prefetch-queue entry layout {instr, pc}, default
//               reset PC and sequential step, and the occupancy-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Widest address/instruction a queue entry can carry. Narrower
    // instances use the low bits and leave the rest at zero.
    localparam int c_MAX_ADDR_W   = 32;
    localparam int c_MAX_DATA_W   = 32;

    localparam int c_DEF_RESET_PC = 0;
    localparam int c_DEF_PC_STEP  = 4;

    typedef struct packed {
        logic [c_MAX_DATA_W-1:0] instr;
        logic [c_MAX_ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Width able to hold 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Bus bundle of the fetch front end: instruction-memory request
//               port, EX redirect input, decode-side valid/ready head and the
//               occupancy debug output.
//               master : the fetch_queue side
//               slave  : the environment (memory, EX, decode)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    import fetch_pkg::*;

    localparam int c_OCC_W = occ_width(DEPTH);

    logic                imem_req;
    logic [ADDR_W-1:0]   imem_addr;
    logic [DATA_W-1:0]   imem_rdata;
    logic                redirect_valid;
    logic [ADDR_W-1:0]   redirect_pc;
    logic                instr_valid;
    logic [DATA_W-1:0]   instr;
    logic [ADDR_W-1:0]   instr_pc;
    logic                instr_ready;
    logic [c_OCC_W-1:0]  occupancy;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        output occupancy
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        input  occupancy
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous show-ahead FIFO of fetch entries. The head is held
//               in a register that is loaded at the same edge as the push or
//               pop that changes it, so o_data is valid the cycle after the
//               first push. When empty, o_data keeps its last value. Flush
//               wins over push and pop.
// Ports       : clk, rst_n        clock, async active-low reset
//               i_push, i_data    write an entry
//               i_pop             consume the head
//               i_flush           discard all entries
//               o_valid, o_data   head entry
//               o_count           entries held
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = occ_width(DEPTH)
)(
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_push,
    input  wire logic          i_pop,
    input  wire logic          i_flush,
    input  wire fetch_entry_t  i_data,
    output fetch_entry_t       o_data,
    output logic               o_valid,
    output logic [CNT_W-1:0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);

    fetch_entry_t        r_mem [DEPTH];
    fetch_entry_t        r_head;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_pop;
    logic [c_PTR_W-1:0]  w_next_rd;
    logic [CNT_W-1:0]    w_remaining;

    assign w_pop       = i_pop & (r_count != '0);
    assign w_next_rd   = w_pop ? r_rd_ptr + c_PTR_W'(1) : r_rd_ptr;
    assign w_remaining = r_count - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            r_rd_ptr <= w_next_rd;
            r_count  <= w_remaining + CNT_W'(i_push);
            // Entries left after the pop already sit in storage; if none are
            // left, the incoming entry becomes the head directly.
            if (w_remaining != '0) begin
                r_head <= r_mem[w_next_rd];
            end else if (i_push) begin
                r_head <= i_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    // Credits upstream must make a push into a full queue impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_flush && r_count == CNT_W'(DEPTH)));

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction-fetch front end: PC generator, fixed one-cycle
//               instruction-memory request port and DEPTH-entry prefetch
//               queue drained by decode. EX redirects flush the queue, toggle
//               the epoch and restart fetch at the redirect target.
// Ports       : clock   rising-edge clock
//               reset   asynchronous active-low reset
//               bus     fetch_queue_if.master (imem, redirect, decode head,
//                       occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(c_DEF_PC_STEP)
)(
    input  wire logic      clock,
    input  wire logic      reset,
    fetch_queue_if.master  bus
);

    localparam int c_CNT_W = occ_width(DEPTH);

    logic [ADDR_W-1:0]   r_fetch_pc;
    logic                r_inflight;
    logic [ADDR_W-1:0]   r_inflight_pc;
    logic                r_inflight_epoch;
    logic                r_epoch;

    logic [c_CNT_W-1:0]  w_count;
    logic                w_head_valid;
    fetch_entry_t        w_head_entry;
    fetch_entry_t        w_push_entry;
    logic                w_pop;
    logic                w_push;
    logic                w_req;
    logic [c_CNT_W:0]    w_credit_used;

    assign w_pop = w_head_valid & bus.instr_ready & ~bus.redirect_valid;

    // Slots spoken for after this cycle: held entries plus the response in
    // flight, minus the one decode is taking now. Counting the pop lets a
    // full queue refill without a bubble.
    assign w_credit_used = {1'b0, w_count}
                         + {{c_CNT_W{1'b0}}, r_inflight}
                         - {{c_CNT_W{1'b0}}, w_pop};

    // The reset term keeps the request low while reset is held, so the first
    // request is taken on the first edge after release.
    assign w_req = reset & ~bus.redirect_valid
                 & (w_credit_used < (c_CNT_W+1)'(DEPTH));

    // A response from an older epoch belongs to a squashed fetch stream.
    assign w_push = r_inflight & (r_inflight_epoch == r_epoch)
                  & ~bus.redirect_valid;

    always_comb begin
        w_push_entry                    = '0;
        w_push_entry.instr[DATA_W-1:0]  = bus.imem_rdata;
        w_push_entry.pc[ADDR_W-1:0]     = r_inflight_pc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc       <= RESET_PC;
            r_inflight       <= 1'b0;
            r_inflight_pc    <= '0;
            r_inflight_epoch <= 1'b0;
            r_epoch          <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_epoch    <= ~r_epoch;
            r_fetch_pc <= bus.redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_inflight_pc    <= r_fetch_pc;
                r_inflight_epoch <= r_epoch;
                r_fetch_pc       <= r_fetch_pc + PC_STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .CNT_W   (c_CNT_W)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  (w_push_entry),
        .o_data  (w_head_entry),
        .o_valid (w_head_valid),
        .o_count (w_count)
    );

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_fetch_pc;
    assign bus.instr_valid = w_head_valid;
    assign bus.instr       = w_head_entry.instr[DATA_W-1:0];
    assign bus.instr_pc    = w_head_entry.pc[ADDR_W-1:0];
    assign bus.occupancy   = w_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Directed self-checking bench for fetch_queue. One 32-bit
//               instance (RESET_PC 0) and one 8-bit address instance
//               (RESET_PC F8) share clock and reset. Memory returns
//               addr ^ 32'hA5A5_0000 one cycle after each request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) bus_a ();
    fetch_queue_if #(.ADDR_W(8),  .DATA_W(32), .DEPTH(4)) bus_w ();

    fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4),
        .RESET_PC(32'h0000_0000), .PC_STEP(32'd4)
    ) dut_a (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_a)
    );

    fetch_queue #(
        .ADDR_W(8), .DATA_W(32), .DEPTH(4),
        .RESET_PC(8'hF8), .PC_STEP(8'd4)
    ) dut_w (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus_w)
    );

    // One-cycle instruction memory models
    always @(posedge clk) begin
        bus_a.imem_rdata <= bus_a.imem_req ? (bus_a.imem_addr ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
        bus_w.imem_rdata <= bus_w.imem_req ? ({24'h0, bus_w.imem_addr} ^ 32'hA5A5_0000) : 32'hDEAD_BEEF;
    end

    // Put both DUTs in reset, then release at a falling edge. Returns #1
    // after release ("cycle 0").
    task automatic start_run(input logic ready);
        @(negedge clk);
        rst_n                = 1'b0;
        bus_a.instr_ready    = ready;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus_a.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus_a.imem_req); end
        n_vec++; if (bus_a.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", bus_a.imem_addr); end
        n_vec++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus_a.instr_valid); end
        n_vec++; if (bus_a.instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", bus_a.instr); end
        n_vec++; if (bus_a.instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", bus_a.instr_pc); end
        n_vec++; if (bus_a.occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", bus_a.occupancy); end
        n_vec++; if (bus_w.imem_addr !== 8'hF8) begin n_err++; $display("FAIL reset_addr_w: got %h want f8", bus_w.imem_addr); end
        n_vec++; if (bus_w.imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req_w: got %b want 0", bus_w.imem_req); end
    endtask

    task automatic test_stream();
        logic [31:0] e_addr, e_pc;
        start_run(1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            e_addr = 32'(4 * k);
            n_vec++; if (bus_a.imem_req !== 1'b1) begin n_err++; $display("FAIL stream_req k=%0d: got %b want 1", k, bus_a.imem_req); end
            n_vec++; if (bus_a.imem_addr !== e_addr) begin n_err++; $display("FAIL stream_addr k=%0d: got %h want %h", k, bus_a.imem_addr, e_addr); end
            if (k < 2) begin
                n_vec++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL stream_early_valid k=%0d: got %b want 0", k, bus_a.instr_valid); end
            end else begin
                e_pc = 32'(4 * (k - 2));
                n_vec++; if (bus_a.instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid k=%0d: got %b want 1", k, bus_a.instr_valid); end
                n_vec++; if (bus_a.instr_pc !== e_pc) begin n_err++; $display("FAIL stream_pc k=%0d: got %h want %h", k, bus_a.instr_pc, e_pc); end
                n_vec++; if (bus_a.instr !== (e_pc ^ 32'hA5A5_0000)) begin n_err++; $display("FAIL stream_instr k=%0d: got %h want %h", k, bus_a.instr, e_pc ^ 32'hA5A5_0000); end
            end
        end
    endtask

    task automatic test_stall();
        int          reqs;
        logic        e_req;
        logic [31:0] e_pc;
        reqs = 0;
        start_run(1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            e_req = (k < 4);
            if (bus_a.imem_req === 1'b1) reqs++;
            n_vec++; if (bus_a.imem_req !== e_req) begin n_err++; $display("FAIL stall_req k=%0d: got %b want %b", k, bus_a.imem_req, e_req); end
        end
        n_vec++; if (reqs != 4) begin n_err++; $display("FAIL stall_req_count: got %0d want 4", reqs); end
        n_vec++; if (bus_a.occupancy !== 3'd4) begin n_err++; $display("FAIL stall_occ: got %0d want 4", bus_a.occupancy); end
        n_vec++; if (bus_a.instr_pc !== 32'h0) begin n_err++; $display("FAIL stall_pc: got %h want 0", bus_a.instr_pc); end
        @(negedge clk);
        bus_a.instr_ready = 1'b1;
        #1;
        n_vec++; if (bus_a.imem_req !== 1'b1) begin n_err++; $display("FAIL stall_refill_req: got %b want 1", bus_a.imem_req); end
        n_vec++; if (bus_a.imem_addr !== 32'h10) begin n_err++; $display("FAIL stall_refill_addr: got %h want 10", bus_a.imem_addr); end
        for (int j = 0; j < 5; j++) begin
            if (j > 0) begin @(negedge clk); #1; end
            e_pc = 32'(4 * j);
            n_vec++; if (bus_a.instr_pc !== e_pc || bus_a.instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_drain j=%0d: got pc %h valid %b want pc %h valid 1", j, bus_a.instr_pc, bus_a.instr_valid, e_pc); end
        end
    endtask

    task automatic test_redirect();
        start_run(1'b1);
        for (int k = 1; k < 5; k++) begin @(negedge clk); #1; end
        // Cycle 5: response for 0x10 arrives while EX redirects to 0x100
        @(negedge clk);
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 32'h100;
        #1;
        n_vec++; if (bus_a.imem_req !== 1'b0) begin n_err++; $display("FAIL redir_req: got %b want 0", bus_a.imem_req); end
        @(negedge clk);
        bus_a.redirect_valid = 1'b0;
        #1;
        n_vec++; if (bus_a.occupancy !== 3'd0) begin n_err++; $display("FAIL redir_occ: got %0d want 0", bus_a.occupancy); end
        n_vec++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid_t1: got %b want 0", bus_a.instr_valid); end
        n_vec++; if (bus_a.imem_addr !== 32'h100 || bus_a.imem_req !== 1'b1) begin n_err++; $display("FAIL redir_addr: got %h req %b want 100 req 1", bus_a.imem_addr, bus_a.imem_req); end
        @(negedge clk); #1;
        n_vec++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid_t2: got %b want 0", bus_a.instr_valid); end
        @(negedge clk); #1;
        n_vec++; if (bus_a.instr_valid !== 1'b1 || bus_a.instr_pc !== 32'h100) begin n_err++; $display("FAIL redir_target: got valid %b pc %h want valid 1 pc 100", bus_a.instr_valid, bus_a.instr_pc); end
        n_vec++; if (bus_a.instr !== 32'hA5A5_0100) begin n_err++; $display("FAIL redir_instr: got %h want a5a50100", bus_a.instr); end
    endtask

    task automatic test_flush_pop_push();
        start_run(1'b1);
        for (int k = 1; k < 3; k++) begin @(negedge clk); #1; end
        // Cycle 3: head pc 4 would pop and response for 8 would push
        @(negedge clk);
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 32'h200;
        #1;
        n_vec++; if (bus_a.instr_valid !== 1'b1 || bus_a.instr_pc !== 32'h4) begin n_err++; $display("FAIL fpp_head: got valid %b pc %h want valid 1 pc 4", bus_a.instr_valid, bus_a.instr_pc); end
        @(negedge clk);
        bus_a.redirect_valid = 1'b0;
        #1;
        n_vec++; if (bus_a.occupancy !== 3'd0 || bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL fpp_flush: got occ %0d valid %b want occ 0 valid 0", bus_a.occupancy, bus_a.instr_valid); end
        n_vec++; if (bus_a.instr_pc !== 32'h4) begin n_err++; $display("FAIL fpp_hold_pc: got %h want 4", bus_a.instr_pc); end
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_vec++; if (bus_a.instr_valid !== 1'b1 || bus_a.instr_pc !== 32'h200) begin n_err++; $display("FAIL fpp_target: got valid %b pc %h want valid 1 pc 200", bus_a.instr_valid, bus_a.instr_pc); end
    endtask

    task automatic test_back_to_back();
        start_run(1'b1);
        for (int k = 1; k < 3; k++) begin @(negedge clk); #1; end
        @(negedge clk);
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 32'h300;
        #1;
        @(negedge clk);
        bus_a.redirect_pc    = 32'h400;
        #1;
        n_vec++; if (bus_a.imem_addr !== 32'h300 || bus_a.imem_req !== 1'b0) begin n_err++; $display("FAIL b2b_mid: got addr %h req %b want addr 300 req 0", bus_a.imem_addr, bus_a.imem_req); end
        @(negedge clk);
        bus_a.redirect_valid = 1'b0;
        #1;
        n_vec++; if (bus_a.imem_addr !== 32'h400 || bus_a.imem_req !== 1'b1) begin n_err++; $display("FAIL b2b_addr: got addr %h req %b want addr 400 req 1", bus_a.imem_addr, bus_a.imem_req); end
        n_vec++; if (bus_a.occupancy !== 3'd0) begin n_err++; $display("FAIL b2b_occ: got %0d want 0", bus_a.occupancy); end
        @(negedge clk); #1;
        n_vec++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_early: got %b want 0", bus_a.instr_valid); end
        @(negedge clk); #1;
        n_vec++; if (bus_a.instr_valid !== 1'b1 || bus_a.instr_pc !== 32'h400) begin n_err++; $display("FAIL b2b_target: got valid %b pc %h want valid 1 pc 400", bus_a.instr_valid, bus_a.instr_pc); end
    endtask

    task automatic test_wrap();
        logic [7:0] e_addr, e_pc;
        start_run(1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            e_addr = 8'hF8 + 8'(4 * k);
            n_vec++; if (bus_w.imem_addr !== e_addr) begin n_err++; $display("FAIL wrap_addr k=%0d: got %h want %h", k, bus_w.imem_addr, e_addr); end
            n_vec++; if (bus_w.occupancy > 3'd4) begin n_err++; $display("FAIL wrap_occ k=%0d: got %0d want <=4", k, bus_w.occupancy); end
            if (k >= 2) begin
                e_pc = 8'hF8 + 8'(4 * (k - 2));
                n_vec++; if (bus_w.instr_valid !== 1'b1 || bus_w.instr_pc !== e_pc) begin n_err++; $display("FAIL wrap_pc k=%0d: got valid %b pc %h want valid 1 pc %h", k, bus_w.instr_valid, bus_w.instr_pc, e_pc); end
            end
        end
    endtask

    task automatic test_reset_mid();
        start_run(1'b0);
        for (int k = 1; k < 5; k++) begin @(negedge clk); #1; end
        n_vec++; if (bus_a.occupancy !== 3'd3) begin n_err++; $display("FAIL mid_occ_before: got %0d want 3", bus_a.occupancy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus_a.occupancy !== 3'd0 || bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_clear: got occ %0d valid %b want occ 0 valid 0", bus_a.occupancy, bus_a.instr_valid); end
        n_vec++; if (bus_a.instr !== 32'h0 || bus_a.instr_pc !== 32'h0) begin n_err++; $display("FAIL mid_async_head: got instr %h pc %h want 0 0", bus_a.instr, bus_a.instr_pc); end
        n_vec++; if (bus_a.imem_req !== 1'b0 || bus_a.imem_addr !== 32'h0) begin n_err++; $display("FAIL mid_async_req: got req %b addr %h want 0 0", bus_a.imem_req, bus_a.imem_addr); end
        @(negedge clk);
        @(negedge clk);
        bus_a.instr_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        n_vec++; if (bus_a.imem_req !== 1'b1 || bus_a.imem_addr !== 32'h0) begin n_err++; $display("FAIL mid_restart: got req %b addr %h want 1 0", bus_a.imem_req, bus_a.imem_addr); end
        @(negedge clk); #1;
        n_vec++; if (bus_a.instr_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale: got valid %b want 0", bus_a.instr_valid); end
        @(negedge clk); #1;
        n_vec++; if (bus_a.instr_valid !== 1'b1 || bus_a.instr_pc !== 32'h0 || bus_a.instr !== 32'hA5A5_0000) begin n_err++; $display("FAIL mid_first: got valid %b pc %h instr %h want 1 0 a5a50000", bus_a.instr_valid, bus_a.instr_pc, bus_a.instr); end
        @(negedge clk); #1;
        n_vec++; if (bus_a.instr_pc !== 32'h4) begin n_err++; $display("FAIL mid_second: got %h want 4", bus_a.instr_pc); end
    endtask

    initial begin
        bus_a.instr_ready    = 1'b1;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = '0;
        bus_w.instr_ready    = 1'b1;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = '0;

        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_flush_pop_push();
        test_back_to_back();
        test_wrap();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
